// File: rtl/spi_ioc_master.sv
// SPI mode-0 slave front-end: decodes 16-bit host frames (W, sel, ioc, data)
// into single-cycle fetch/load strobes toward io_ctrl-style responders.
module spi_ioc_master #(
    parameter int N_MODULES   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     i_sys_clk,
    input  logic                     i_reset,
    input  logic                     i_spi_sck,
    input  logic                     i_spi_mosi,
    input  logic                     i_spi_cs_n,
    output logic                     o_spi_miso,
    output logic [4:0]               o_ioc,
    output logic [7:0]               o_data_out,
    output logic [N_MODULES-1:0]     o_cs,
    output logic                     o_fetch_cmd,
    output logic                     o_load_cmd,
    input  logic [8*N_MODULES-1:0]   i_data_in,
    output logic                     o_frame_abort
);

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_CMD       = 3'd2,
        ST_FETCH     = 3'd3,
        ST_CAPT      = 3'd4,
        ST_DATA      = 3'd5,
        ST_LOAD      = 3'd6
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nx;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_n_sync;
    logic                   r_sck_d;
    logic [3:0]             r_bit_cnt;
    logic [7:0]             r_shift_in;
    logic [7:0]             r_miso_sr;
    logic [1:0]             r_sel;
    logic                   r_write;

    logic                   w_sck;
    logic                   w_mosi;
    logic                   w_cs_n;
    logic                   w_sck_rise;
    logic [7:0]             w_shift_nx;
    logic                   w_sel_ok_hdr;
    logic                   w_sel_ok;
    logic [1:0]             w_cs_sel;
    logic                   w_abort;
    logic                   w_hdr_done;
    logic [7:0]             w_miso_nx;
    logic [7:0]             w_rd_byte;
    logic [N_MODULES-1:0]   w_cs_onehot;

    assign w_sck        = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi       = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_n       = r_cs_n_sync[SYNC_STAGES-1];
    assign w_sck_rise   = w_sck & ~r_sck_d;
    assign w_shift_nx   = {r_shift_in[6:0], w_mosi};
    assign w_sel_ok_hdr = ({1'b0, w_shift_nx[6:5]} < 3'(N_MODULES));
    assign w_sel_ok     = ({1'b0, r_sel} < 3'(N_MODULES));
    assign w_cs_sel     = (r_state == ST_CMD) ? w_shift_nx[6:5] : r_sel;

    // Input synchronisers; CS_N chain clears to 0 so a reset mid-frame waits in WAIT_IDLE.
    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            r_sck_sync  <= {SYNC_STAGES{1'b0}};
            r_mosi_sync <= {SYNC_STAGES{1'b0}};
            r_cs_n_sync <= {SYNC_STAGES{1'b0}};
            r_sck_d     <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_spi_sck};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
            r_cs_n_sync <= {r_cs_n_sync[SYNC_STAGES-2:0], i_spi_cs_n};
            r_sck_d     <= w_sck;
        end
    end

    // Responder read-data mux and one-hot select decode.
    always_comb begin
        w_rd_byte   = 8'h00;
        w_cs_onehot = {N_MODULES{1'b0}};
        for (int k = 0; k < N_MODULES; k++) begin
            w_rd_byte      = w_rd_byte | (i_data_in[8*k +: 8] & {8{r_sel == 2'(k)}});
            w_cs_onehot[k] = (w_cs_sel == 2'(k));
        end
    end

    // State register.
    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            r_state <= ST_WAIT_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state, abort detection and MISO shift-register next value.
    always_comb begin
        w_state_nx = r_state;
        w_abort    = 1'b0;
        w_hdr_done = 1'b0;
        w_miso_nx  = r_miso_sr;
        case (r_state)
            ST_WAIT_IDLE: begin
                if (w_cs_n) w_state_nx = ST_IDLE;
                else        w_state_nx = ST_WAIT_IDLE;
            end
            ST_IDLE: begin
                if (!w_cs_n) w_state_nx = ST_CMD;
                else         w_state_nx = ST_IDLE;
            end
            ST_CMD: begin
                // A release with no bits shifted is the normal end after a completed frame.
                if (w_cs_n) begin
                    w_state_nx = ST_IDLE;
                    w_abort    = (r_bit_cnt != 4'd0);
                    w_miso_nx  = 8'h00;
                end else if (w_sck_rise && (r_bit_cnt == 4'd7)) begin
                    w_hdr_done = 1'b1;
                    w_miso_nx  = 8'h00;
                    if (!w_shift_nx[7] && w_sel_ok_hdr) w_state_nx = ST_FETCH;
                    else                                w_state_nx = ST_DATA;
                end else begin
                    w_state_nx = ST_CMD;
                end
            end
            ST_FETCH: begin
                if (w_cs_n) begin
                    w_state_nx = ST_IDLE;
                    w_abort    = 1'b1;
                    w_miso_nx  = 8'h00;
                end else begin
                    w_state_nx = ST_CAPT;
                end
            end
            ST_CAPT: begin
                if (w_cs_n) begin
                    w_state_nx = ST_IDLE;
                    w_abort    = 1'b1;
                    w_miso_nx  = 8'h00;
                end else begin
                    w_state_nx = ST_DATA;
                    w_miso_nx  = w_rd_byte;
                end
            end
            ST_DATA: begin
                if (w_sck_rise && (r_bit_cnt == 4'd15)) begin
                    w_miso_nx = 8'h00;
                    if (r_write && w_sel_ok) w_state_nx = ST_LOAD;
                    else if (w_cs_n)         w_state_nx = ST_IDLE;
                    else                     w_state_nx = ST_CMD;
                end else if (w_cs_n) begin
                    w_state_nx = ST_IDLE;
                    w_abort    = 1'b1;
                    w_miso_nx  = 8'h00;
                end else if (w_sck_rise) begin
                    w_miso_nx  = {r_miso_sr[6:0], 1'b0};
                end else begin
                    w_state_nx = ST_DATA;
                end
            end
            ST_LOAD: begin
                if (w_cs_n) w_state_nx = ST_IDLE;
                else        w_state_nx = ST_CMD;
            end
            default: begin
                w_state_nx = ST_WAIT_IDLE;
                w_miso_nx  = 8'h00;
            end
        endcase
    end

    // Datapath and registered outputs, decoded from the next state so strobes land 1 cycle after the edge.
    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            o_spi_miso    <= 1'b0;
            o_ioc         <= 5'd0;
            o_data_out    <= 8'h00;
            o_cs          <= {N_MODULES{1'b0}};
            o_fetch_cmd   <= 1'b0;
            o_load_cmd    <= 1'b0;
            o_frame_abort <= 1'b0;
            r_bit_cnt     <= 4'd0;
            r_shift_in    <= 8'h00;
            r_miso_sr     <= 8'h00;
            r_sel         <= 2'd0;
            r_write       <= 1'b0;
        end else begin
            o_fetch_cmd   <= (w_state_nx == ST_FETCH);
            o_load_cmd    <= (w_state_nx == ST_LOAD);
            o_cs          <= ((w_state_nx == ST_FETCH) || (w_state_nx == ST_LOAD)) ?
                             w_cs_onehot : {N_MODULES{1'b0}};
            o_frame_abort <= w_abort;
            r_miso_sr     <= w_miso_nx;
            o_spi_miso    <= (w_state_nx == ST_DATA) ? w_miso_nx[7] : 1'b0;
            if (w_hdr_done) begin
                o_ioc   <= w_shift_nx[4:0];
                r_sel   <= w_shift_nx[6:5];
                r_write <= w_shift_nx[7];
            end
            if (w_state_nx == ST_LOAD) begin
                o_data_out <= w_shift_nx;
            end
            if (r_state == ST_IDLE) begin
                r_bit_cnt <= 4'd0;
            end else if (w_sck_rise && ((r_state == ST_CMD) || (r_state == ST_DATA))) begin
                r_bit_cnt  <= r_bit_cnt + 4'd1;
                r_shift_in <= w_shift_nx;
            end
        end
    end

endmodule
